fetch: RTL

Instruction-fetch stage and IF/ID pipeline register of the 16-bit pipelined core. It owns the PC, issues single-outstanding requests to instruction memory, and presents `instr`, `next_pc_basic` and `valid` to decode. It honours hazard stalls from downstream and branch/jump redirects from execute, and optionally stops fetching at HALT.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_hold_buf.sv | 40 ++++
 rtl/fetch.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch stage.
//   - state encodings for the fetch sequencer
//   - HALT opcode and a helper to recognise it
//   - default NOP instruction and reset PC
package fetch_pkg;

    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    localparam logic [4:0]  OPC_HALT      = 5'b00000;
    localparam logic [15:0] DEF_NOP_INSTR = 16'h0800;
    localparam logic [15:0] DEF_RESET_PC  = 16'h0000;

    // Opcode lives in the top five bits of the instruction word.
    function automatic logic is_halt(input logic [15:0] word);
        return word[15:11] == OPC_HALT;
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: one-entry buffer for an instruction word that arrived while
// decode was stalled.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   i_load, i_data capture a word (sets the valid bit)
//   i_drain        word consumed, clear the valid bit
//   i_flush        discard the word (wins over i_load)
//   o_valid/o_data buffer contents
module fetch_hold_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [15:0] i_data,
    input  logic        i_drain,
    input  logic        i_flush,
    output logic        o_valid,
    output logic [15:0] o_data
);

    logic        r_valid;
    logic [15:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= 16'h0000;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/fetch.sv
// fetch: instruction-fetch stage and IF/ID pipeline register.
// Owns the PC, issues single-outstanding requests to instruction memory and
// presents instr / next_pc_basic / valid to decode. Honours downstream stalls
// and execute redirects.
// Optional feature macro: FETCH_HALT_EN (stop fetching after a HALT word is
// loaded into IF/ID; a redirect resumes). Undefined: halted is tied to 0.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   stall                       hold IF/ID this cycle
//   redirect, redirect_pc       flush and refetch from redirect_pc
//   imem_req, imem_addr         memory request (address stable while req high)
//   imem_rdata, imem_done       memory response
//   instr, next_pc_basic, valid IF/ID register
//   halted                      fetch stopped at HALT
//   err                         sticky: an odd redirect target was seen
module fetch
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [15:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_done,
    output logic [15:0] instr,
    output logic [15:0] next_pc_basic,
    output logic        valid,
    output logic        halted,
    output logic        err
);

    logic [1:0]  r_state;
    logic [15:0] r_pc;
    logic [15:0] r_addr;
    logic [15:0] r_instr;
    logic [15:0] r_npc;
    logic        r_valid;
    logic        r_err;

    logic [1:0]  w_state_nxt;
    logic [15:0] w_pc_nxt;
    logic [15:0] w_addr_nxt;
    logic [15:0] w_instr_nxt;
    logic [15:0] w_npc_nxt;
    logic        w_valid_nxt;
    logic        w_err_nxt;

    logic        w_req;
    logic [15:0] w_target;
    logic [15:0] w_pc_plus2;
    logic        w_load;
    logic [15:0] w_load_word;
    logic [15:0] w_load_npc;
    logic        w_buf_load;
    logic        w_buf_drain;
    logic        w_buf_flush;
    logic        w_buf_valid;
    logic [15:0] w_buf_data;

    assign w_req      = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
    assign w_target   = {redirect_pc[15:1], 1'b0};
    assign w_pc_plus2 = r_pc + 16'd2;

    fetch_hold_buf u_hold_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_buf_load),
        .i_data  (imem_rdata),
        .i_drain (w_buf_drain),
        .i_flush (w_buf_flush),
        .o_valid (w_buf_valid),
        .o_data  (w_buf_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_addr_nxt  = r_addr;
        w_instr_nxt = r_instr;
        w_npc_nxt   = r_npc;
        w_valid_nxt = r_valid;
        w_err_nxt   = r_err | (redirect & redirect_pc[0]);
        w_load      = 1'b0;
        w_load_word = 16'h0000;
        w_load_npc  = 16'h0000;
        w_buf_load  = 1'b0;
        w_buf_drain = 1'b0;
        w_buf_flush = 1'b0;

        if (redirect) begin
            w_pc_nxt    = w_target;
            w_valid_nxt = 1'b0;
            w_instr_nxt = NOP_INSTR;
            w_buf_flush = 1'b1;
            // An unanswered request must be drained; its address stays on the bus.
            if (w_req && !imem_done) begin
                w_state_nxt = ST_DRAIN;
            end else begin
                w_state_nxt = ST_FETCH;
                w_addr_nxt  = w_target;
            end
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (imem_done) begin
                        w_pc_nxt   = w_pc_plus2;
                        w_addr_nxt = w_pc_plus2;
                        if (stall) begin
                            w_buf_load  = 1'b1;
                            w_state_nxt = ST_HOLD;
                        end else begin
                            w_load      = 1'b1;
                            w_load_word = imem_rdata;
                            w_load_npc  = w_pc_plus2;
                        end
                    end else if (!stall) begin
                        // Decode consumed the entry and nothing new arrived: bubble.
                        w_valid_nxt = 1'b0;
                        w_instr_nxt = NOP_INSTR;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        w_buf_drain = 1'b1;
                        w_state_nxt = ST_FETCH;
                        if (w_buf_valid) begin
                            w_load      = 1'b1;
                            w_load_word = w_buf_data;
                            // PC already advanced past the buffered word.
                            w_load_npc  = r_pc;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (imem_done) begin
                        w_state_nxt = ST_FETCH;
                        w_addr_nxt  = r_pc;
                    end
                end
`ifdef FETCH_HALT_EN
                ST_HALTED: begin
                    if (!stall) begin
                        w_valid_nxt = 1'b0;
                        w_instr_nxt = NOP_INSTR;
                    end
                end
`endif
                default: w_state_nxt = ST_FETCH;
            endcase
        end

        if (w_load) begin
            w_instr_nxt = w_load_word;
            w_npc_nxt   = w_load_npc;
            w_valid_nxt = 1'b1;
`ifdef FETCH_HALT_EN
            if (is_halt(w_load_word)) begin
                w_state_nxt = ST_HALTED;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
            r_instr <= NOP_INSTR;
            r_npc   <= 16'h0000;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_addr  <= w_addr_nxt;
            r_instr <= w_instr_nxt;
            r_npc   <= w_npc_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
        end
    end

`ifdef FETCH_HALT_EN
    logic r_halted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halted <= 1'b0;
        end else begin
            r_halted <= (w_state_nxt == ST_HALTED);
        end
    end

    assign halted = r_halted;
`else
    assign halted = 1'b0;
`endif

    assign imem_req      = w_req;
    assign imem_addr     = r_addr;
    assign instr         = r_instr;
    assign next_pc_basic = r_npc;
    assign valid         = r_valid;
    assign err           = r_err;

endmodule
